// File: rtl/mult_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_mac_pkg
// Description : Shared types, default widths and helper functions for the
//               mult_mac_pipe multiply-accumulate lane.
//               ctrl_t    - control bits travelling beside the product
//               ext_prod  - sign/zero extension of the raw product
//               sat_limit - saturation value for a given mode and addend sign
// Revision    : 1.0 - initial release
// ============================================================================
package mult_mac_pkg;

  localparam int DEF_A_W         = 18;
  localparam int DEF_B_W         = 18;
  localparam int DEF_ACC_W       = 48;
  localparam int DEF_PROD_STAGES = 1;

  // Helpers work on a fixed wide vector; callers pass masks and truncate.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic sgn;
  } ctrl_t;

  // Bits inside keep_mask come from prod; bits above are filled with fill_bit
  // (the product MSB for signed samples, 0 for unsigned ones).
  function automatic logic [MAX_W-1:0] ext_prod(input logic [MAX_W-1:0] prod,
                                                input logic [MAX_W-1:0] keep_mask,
                                                input logic             fill_bit);
    return (prod & keep_mask) | (~keep_mask & {MAX_W{fill_bit}});
  endfunction

  // acc_mask has the low ACC_W bits set. Signed: max positive or min negative
  // depending on the addend sign. Unsigned: all ones.
  function automatic logic [MAX_W-1:0] sat_limit(input logic             sgn,
                                                 input logic             neg,
                                                 input logic [MAX_W-1:0] acc_mask);
    logic [MAX_W-1:0] lim;
    if (!sgn)     lim = acc_mask;
    else if (neg) lim = acc_mask & ~(acc_mask >> 1);
    else          lim = acc_mask >> 1;
    return lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_reg
// Description : Operand register stage followed by PROD_STAGES free-running
//               product registers. Data registers carry no reset so the whole
//               structure packs into DSP blocks; only the control chain resets.
// Ports       : clk, reset           - clock, async active-high reset
//               in_valid, in_first,
//               in_last, signed_mode - sample control, registered with operands
//               op_a, op_b           - operands
//               prod                 - A_W+B_W bit product (last stage)
//               ctrl                 - control bits aligned with prod
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pipe_reg
  import mult_mac_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int PROD_STAGES = DEF_PROD_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [A_W-1:0]     op_a,
  input  logic [B_W-1:0]     op_b,
  input  logic               signed_mode,
  input  logic               in_first,
  input  logic               in_last,
  output logic [A_W+B_W-1:0] prod,
  output ctrl_t              ctrl
);

  localparam int PROD_W = A_W + B_W;

  logic [A_W-1:0]    a_q;
  logic [B_W-1:0]    b_q;
  ctrl_t             ctrl_op;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] mult;
  logic [PROD_W-1:0] prod_q [PROD_STAGES];
  ctrl_t             ctrl_q [PROD_STAGES];

  always_ff @(posedge clk) begin
    a_q <= op_a;
    b_q <= op_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl_op <= '0;
    else       ctrl_op <= '{valid: in_valid, first: in_first, last: in_last, sgn: signed_mode};
  end

  // Extending both operands to the full product width and keeping the low
  // PROD_W bits of the product gives the exact signed or unsigned result.
  assign a_ext = ctrl_op.sgn ? {{B_W{a_q[A_W-1]}}, a_q} : {{B_W{1'b0}}, a_q};
  assign b_ext = ctrl_op.sgn ? {{A_W{b_q[B_W-1]}}, b_q} : {{A_W{1'b0}}, b_q};
  assign mult  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    prod_q[0] <= mult;
    for (int s = 1; s < PROD_STAGES; s++) prod_q[s] <= prod_q[s-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < PROD_STAGES; s++) ctrl_q[s] <= '0;
    end else begin
      ctrl_q[0] <= ctrl_op;
      for (int s = 1; s < PROD_STAGES; s++) ctrl_q[s] <= ctrl_q[s-1];
    end
  end

  assign prod = prod_q[PROD_STAGES-1];
  assign ctrl = ctrl_q[PROD_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mult_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mult_mac_pipe
// Description : Pipelined multiply-accumulate lane with first/last framing
//               and a sticky overflow flag. Latency from the edge capturing
//               a last sample to out_valid is 2+PROD_STAGES edges.
// Config      : MULT_MAC_SAT_EN - when defined, the accumulator saturates on
//               overflow instead of wrapping modulo 2^ACC_W.
// Ports       : clk, reset          - clock, async active-high reset
//               in_valid, in_first,
//               in_last             - sample qualifier and framing
//               op_a, op_b          - operands
//               signed_mode         - 1 = two's complement, 0 = unsigned
//               out_valid           - one-cycle completion pulse
//               result, overflow    - completed sum and flag, held
// Revision    : 1.0 - initial release
// ============================================================================
module mult_mac_pipe
  import mult_mac_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int PROD_STAGES = DEF_PROD_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [A_W-1:0]   op_a,
  input  logic [B_W-1:0]   op_b,
  input  logic             signed_mode,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam int PROD_W = A_W + B_W;
  localparam logic [MAX_W-1:0] PROD_MASK = ~({MAX_W{1'b1}} << PROD_W);
  localparam logic [MAX_W-1:0] ACC_MASK  = ~({MAX_W{1'b1}} << ACC_W);

  generate
    if (ACC_W < PROD_W || ACC_W > MAX_W) begin : g_bad_acc_w
      $error("mult_mac_pipe: ACC_W must be >= A_W+B_W and <= MAX_W");
    end
    if (PROD_STAGES < 1) begin : g_bad_prod_stages
      $error("mult_mac_pipe: PROD_STAGES must be >= 1");
    end
  endgenerate

  logic [PROD_W-1:0] prod;
  ctrl_t             ctrl;
  logic [ACC_W-1:0]  acc;
  logic              sticky;
  logic              done;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum;
  logic              carry_out;
  logic              carry_msb;
  logic              ovf;
  logic [ACC_W-1:0]  acc_next;

  mult_pipe_reg #(
    .A_W         (A_W),
    .B_W         (B_W),
    .PROD_STAGES (PROD_STAGES)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .signed_mode (signed_mode),
    .in_first    (in_first),
    .in_last     (in_last),
    .prod        (prod),
    .ctrl        (ctrl)
  );

  assign addend = ACC_W'(ext_prod(MAX_W'(prod), PROD_MASK, ctrl.sgn & prod[PROD_W-1]));

  // A first sample restarts from zero, discarding any open partial sum.
  assign base      = ctrl.first ? '0 : acc;
  assign sum       = {1'b0, base} + {1'b0, addend};
  assign carry_out = sum[ACC_W];
  assign carry_msb = base[ACC_W-1] ^ addend[ACC_W-1] ^ sum[ACC_W-1];
  assign ovf       = ctrl.sgn ? (carry_msb ^ carry_out) : carry_out;

`ifdef MULT_MAC_SAT_EN
  logic [ACC_W-1:0] sat_val;
  assign sat_val  = ACC_W'(sat_limit(ctrl.sgn, addend[ACC_W-1], ACC_MASK));
  assign acc_next = ovf ? sat_val : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  // The accumulate stage registers acc and a completion flag; the following
  // edge copies the completed acc/sticky into the held outputs. A new sample
  // landing on that same edge does not disturb the captured value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      sticky    <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      done      <= ctrl.valid & ctrl.last;
      out_valid <= done;
      if (ctrl.valid) begin
        acc    <= acc_next;
        sticky <= ctrl.first ? ovf : (sticky | ovf);
      end
      if (done) begin
        result   <= acc;
        overflow <= sticky;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_mac_pipe
// Description : Scoreboard bench for mult_mac_pipe. Two lanes share one
//               stimulus stream: the default 48-bit accumulator and a 36-bit
//               accumulator that exercises overflow. An arithmetic model
//               predicts each completed accumulation when its last sample is
//               driven; outputs are compared when out_valid pulses, and held
//               values are checked on every other cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_mac_pipe;

  localparam int PROD_STAGES = 1;
  // Drive on a negedge, capture on the next posedge, then 2+PROD_STAGES edges.
  localparam int LATENCY = 1 + 2 + PROD_STAGES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [17:0] op_a = '0;
  logic [17:0] op_b = '0;
  logic        signed_mode = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        ov48, ovf48, ov36, ovf36;
  logic [47:0] res48;
  logic [35:0] res36;

  mult_mac_pipe #(.A_W(18), .B_W(18), .ACC_W(48), .PROD_STAGES(PROD_STAGES)) dut48 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op_a(op_a), .op_b(op_b),
    .signed_mode(signed_mode), .in_first(in_first), .in_last(in_last),
    .out_valid(ov48), .result(res48), .overflow(ovf48));

  mult_mac_pipe #(.A_W(18), .B_W(18), .ACC_W(36), .PROD_STAGES(PROD_STAGES)) dut36 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op_a(op_a), .op_b(op_b),
    .signed_mode(signed_mode), .in_first(in_first), .in_last(in_last),
    .out_valid(ov36), .result(res36), .overflow(ovf36));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    longint r48;
    bit     o48;
    longint r36;
    bit     o36;
    int     cyc;
  } exp_t;
  exp_t q[$];

  longint acc48 = 0, acc36 = 0;
  bit     st48 = 0, st36 = 0;
  longint held_r48 = 0, held_r36 = 0;
  bit     held_o48 = 0, held_o36 = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on true integers; acc holds the w-bit pattern.
  function automatic void mstep(input int w, input logic [17:0] a, input logic [17:0] b,
                                input bit sgn, input bit first,
                                inout longint acc, inout bit st);
    longint mask, hi, lo, p, base, sum;
    bit ov;
    mask = (longint'(1) << w) - 1;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'(a) * longint'(b);
    if (first)                             base = 0;
    else if (sgn && ((acc >> (w - 1)) & 1)) base = acc - (longint'(1) << w);
    else                                   base = acc;
    sum = base + p;
    ov  = sgn ? (sum > hi || sum < lo) : (sum > mask);
`ifdef MULT_MAC_SAT_EN
    if (ov) acc = sgn ? ((p >= 0) ? hi : (longint'(1) << (w - 1))) : mask;
    else    acc = sum & mask;
`else
    acc = sum & mask;
`endif
    st = first ? ov : (st | ov);
  endfunction

  task automatic send(input bit v, input logic [17:0] a, input logic [17:0] b,
                      input bit sgn, input bit f, input bit l);
    exp_t e;
    @(negedge clk);
    in_valid = v; op_a = a; op_b = b; signed_mode = sgn; in_first = f; in_last = l;
    if (v) begin
      mstep(48, a, b, sgn, f, acc48, st48);
      mstep(36, a, b, sgn, f, acc36, st36);
      if (l) begin
        e.r48 = acc48; e.o48 = st48; e.r36 = acc36; e.o36 = st36; e.cyc = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 18'h0, 18'h0, 1'b0, 1'b1, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held_r48 = 0; held_o48 = 0; held_r36 = 0; held_o36 = 0;
    end else if (ov48 || ov36) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_valid48", ov48, 1);
        check("out_valid36", ov36, 1);
        check("latency", cyc - e.cyc, LATENCY);
        check("result48", res48, e.r48);
        check("overflow48", ovf48, e.o48);
        check("result36", res36, e.r36);
        check("overflow36", ovf36, e.o36);
        held_r48 = e.r48; held_o48 = e.o48; held_r36 = e.r36; held_o36 = e.o36;
      end
    end else begin
      check("hold_result48", res48, held_r48);
      check("hold_overflow48", ovf48, held_o48);
      check("hold_result36", res36, held_r36);
      check("hold_overflow36", ovf36, held_o36);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid48", ov48, 0);
    check("rst_result48", res48, 0);
    check("rst_overflow48", ovf48, 0);
    check("rst_out_valid36", ov36, 0);
    check("rst_result36", res36, 0);
    check("rst_overflow36", ovf36, 0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned single-product accumulation: 3*5 = 15.
    send(1, 18'd3, 18'd5, 0, 1, 1);
    idle(5);

    // Signed back-to-back: (-2)*3 + 4*4 = 10.
    send(1, -18'sd2, 18'd3, 1, 1, 0);
    send(1, 18'd4, 18'd4, 1, 0, 1);
    idle(5);

    // Bubbles between samples: 1 + 4 + 9 = 14.
    send(1, 18'd1, 18'd1, 0, 1, 0);
    idle(1);
    send(1, 18'd2, 18'd2, 0, 0, 0);
    idle(3);
    send(1, 18'd3, 18'd3, 0, 0, 1);
    idle(5);

    // Signed overflow in 36 bits: 2 * 2^34 = 2^35.
    send(1, 18'h20000, 18'h20000, 1, 1, 0);
    send(1, 18'h20000, 18'h20000, 1, 0, 1);
    idle(5);

    // Unsigned overflow in 36 bits: 2 * (2^18-1)^2.
    send(1, 18'h3FFFF, 18'h3FFFF, 0, 1, 0);
    send(1, 18'h3FFFF, 18'h3FFFF, 0, 0, 1);
    idle(5);

    // Restart discards the open partial sum 49.
    send(1, 18'd7, 18'd7, 0, 1, 0);
    send(1, 18'd2, 18'd2, 0, 1, 1);
    idle(5);

    // Reset one cycle after a last sample: nothing completes.
    send(1, 18'd5, 18'd5, 0, 1, 0);
    send(1, 18'd1, 18'd1, 0, 0, 1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    q.delete();
    acc48 = 0; acc36 = 0; st48 = 0; st36 = 0;
    repeat (2) @(negedge clk);
    check("midrst_result48", res48, 0);
    check("midrst_overflow48", ovf48, 0);
    check("midrst_result36", res36, 0);
    reset = 1'b0;
    idle(6);

    // No first since reset: accumulates onto zero, 2*3 = 6.
    send(1, 18'd2, 18'd3, 0, 0, 1);
    idle(5);

    // Randomised framing, validity and mode.
    for (int i = 0; i < 60; i++) begin
      send(($urandom_range(0, 3) != 0), 18'($urandom), 18'($urandom),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0));
    end
    idle(2);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("drain_pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
